// File: rtl/asym_pack_fifo_pkg.sv
// Shared defaults and the constant log2 helper for the narrow-to-wide packing FIFO.
package asym_pack_fifo_pkg;

  localparam int DEF_WIDTHIN   = 48;
  localparam int DEF_WIDTHOUT  = 384;
  localparam int DEF_RATIO     = DEF_WIDTHOUT / DEF_WIDTHIN;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_ADDRWIDTH = 4;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/asym_pack_fifo_line_ram.sv
// Simple dual-port line store: one write port, one read port with a registered read.
module line_ram
  import asym_pack_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTHOUT + clog2(DEF_RATIO) + 1,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents and read register are never reset; rd_data holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/asym_pack_fifo.sv
// Packs narrow words into wide lines, queues lines in a RAM, and presents them
// through a show-ahead output register with a one-deep prefetch in the RAM read port.
module asym_pack_fifo
  import asym_pack_fifo_pkg::*;
#(
  parameter int WIDTHIN   = DEF_WIDTHIN,
  parameter int WIDTHOUT  = DEF_WIDTHOUT,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTHIN-1:0]                   in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTHOUT-1:0]                  out_data,
  output logic [clog2(WIDTHOUT/WIDTHIN):0]     out_words,
  output logic [ADDRWIDTH:0]                   level
);

  localparam int RATIO  = WIDTHOUT / WIDTHIN;
  localparam int LANEW  = clog2(RATIO);
  localparam int WORDSW = LANEW + 1;
  localparam int RAMW   = WIDTHOUT + WORDSW;

  localparam logic [LANEW-1:0]     LANE_LAST  = LANEW'(RATIO - 1);
  localparam logic [LANEW-1:0]     LANE_ONE   = LANEW'(1);
  localparam logic [WORDSW-1:0]    WORDS_ONE  = WORDSW'(1);
  localparam logic [ADDRWIDTH-1:0] PTR_LAST   = ADDRWIDTH'(DEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] PTR_ONE    = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH:0]   CNT_ONE    = (ADDRWIDTH+1)'(1);
  localparam logic [ADDRWIDTH:0]   LEVEL_FULL = (ADDRWIDTH+1)'(DEPTH);

  function automatic logic [ADDRWIDTH-1:0] ptr_inc(input logic [ADDRWIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
  endfunction

  logic                  run_reg;
  logic [LANEW-1:0]      lane_reg;
  logic [WIDTHOUT-1:0]   asm_reg;
  logic [WIDTHOUT-1:0]   line_next;
  logic [ADDRWIDTH-1:0]  wr_ptr_reg;
  logic [ADDRWIDTH-1:0]  rd_ptr_reg;
  logic [ADDRWIDTH:0]    unread_reg;
  logic [ADDRWIDTH:0]    level_reg;
  logic                  stage_valid_reg;
  logic                  out_valid_reg;
  logic [WIDTHOUT-1:0]   out_data_reg;
  logic [WORDSW-1:0]     out_words_reg;

  logic                  accept;
  logic                  line_done;
  logic                  consume;
  logic                  out_load;
  logic                  issue;
  logic [WORDSW-1:0]     line_words;
  logic [RAMW-1:0]       ram_wr_data;
  logic [RAMW-1:0]       ram_rd_data;

  // Full counts every held line, including the one sitting in the output register.
  assign in_ready   = run_reg & (level_reg != LEVEL_FULL);
  assign accept     = in_valid & in_ready;
  assign line_done  = accept & (in_last | (lane_reg == LANE_LAST));
  assign line_words = {1'b0, lane_reg} + WORDS_ONE;

  assign consume    = out_valid_reg & out_ready;
  assign out_load   = stage_valid_reg & (~out_valid_reg | out_ready);
  assign issue      = (unread_reg != '0) & (~stage_valid_reg | out_load);

  // Lanes above the current one are already zero in asm_reg, so early lines come out zero-padded.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign line_next[gi*WIDTHIN +: WIDTHIN] =
      (lane_reg == LANEW'(gi)) ? in_data : asm_reg[gi*WIDTHIN +: WIDTHIN];
  end

  assign ram_wr_data = {line_words, line_next};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_reg <= '0;
      asm_reg  <= '0;
    end else if (accept) begin
      if (line_done) begin
        lane_reg <= '0;
        asm_reg  <= '0;
      end else begin
        lane_reg <= lane_reg + LANE_ONE;
        asm_reg  <= line_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (line_done) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (issue) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  // unread_reg: lines in the RAM not yet fetched; level_reg: all complete lines held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unread_reg <= '0;
      level_reg  <= '0;
    end else begin
      case ({line_done, issue})
        2'b10:   unread_reg <= unread_reg + CNT_ONE;
        2'b01:   unread_reg <= unread_reg - CNT_ONE;
        default: unread_reg <= unread_reg;
      endcase
      case ({line_done, consume})
        2'b10:   level_reg <= level_reg + CNT_ONE;
        2'b01:   level_reg <= level_reg - CNT_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_words_reg   <= '0;
    end else begin
      if (issue) begin
        stage_valid_reg <= 1'b1;
      end else if (out_load) begin
        stage_valid_reg <= 1'b0;
      end
      if (out_load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ram_rd_data[WIDTHOUT-1:0];
        out_words_reg <= ram_rd_data[RAMW-1 -: WORDSW];
      end else if (consume) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  line_ram #(
    .WIDTH     (RAMW),
    .DEPTH     (DEPTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (line_done),
    .wr_addr (wr_ptr_reg),
    .wr_data (ram_wr_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_words = out_words_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_asym_pack_fifo.sv
// Randomized and directed bench for asym_pack_fifo, checked every cycle against a queue-level model.
module tb_asym_pack_fifo;

  localparam int WIN   = 48;
  localparam int WOUT  = 384;
  localparam int RATIO = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WIN-1:0]  in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [WOUT-1:0] out_data;
  logic [3:0]      out_words;
  logic [AW:0]     level;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  bit prod_done;

  typedef struct {
    logic [WOUT-1:0] data;
    int              words;
    int              edge_n;
  } line_t;

  line_t          exp_q[$];
  logic [WIN-1:0] asm_q[$];
  bit             run_m = 0;

  asym_pack_fifo #(
    .WIDTHIN   (WIN),
    .WIDTHOUT  (WOUT),
    .DEPTH     (DEPTH),
    .ADDRWIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_words (out_words),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input logic [WOUT-1:0] act, input logic [WOUT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a line is visible at the output once it completed at least two edges ago.
  always @(negedge clk) begin
    logic            exp_ready;
    logic            exp_ov;
    line_t           ln;
    if (reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_words", out_words, 0);
      check("rst_level", level, 0);
      exp_q.delete();
      asm_q.delete();
      run_m = 0;
    end else begin
      exp_ready = run_m && (exp_q.size() != DEPTH);
      exp_ov    = (exp_q.size() > 0) && (exp_q[0].edge_n + 2 <= ecount);
      check("in_ready", in_ready, exp_ready);
      check("level", level, exp_q.size());
      check("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check("out_data", out_data, exp_q[0].data);
        check("out_words", out_words, exp_q[0].words);
      end
      if (exp_ov && out_ready) begin
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_ready) begin
        asm_q.push_back(in_data);
        if (in_last || asm_q.size() == RATIO) begin
          ln.data = '0;
          for (int k = 0; k < asm_q.size(); k++) ln.data[k*WIN +: WIN] = asm_q[k];
          ln.words  = asm_q.size();
          ln.edge_n = ecount + 1;
          exp_q.push_back(ln);
          asm_q.delete();
        end
      end
      run_m = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIN-1:0] d, input bit last);
    int  t;
    bit  acc;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accepted");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (level != 0 && t < 500) begin
      step();
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", level);
    end
    repeat (3) step();
  endtask

  function automatic logic [WIN-1:0] rand_word();
    return {16'($urandom()), $urandom()};
  endfunction

  initial begin
    #600000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Full line of 1..8
    out_ready = 1'b1;
    for (int k = 0; k < RATIO; k++) send_word(WIN'(k + 1), 1'b0);
    step();
    check("lat_n1_valid", out_valid, 0);
    step();
    check("lat_n2_valid", out_valid, 1);
    check("line_w0", out_data[47:0], 48'h1);
    check("line_w3", out_data[191:144], 48'h4);
    check("line_w7", out_data[383:336], 48'h8);
    check("line_words", out_words, 8);
    repeat (4) step();

    // Early close after three words
    send_word(48'hA, 1'b0);
    send_word(48'hB, 1'b0);
    send_word(48'hC, 1'b1);
    step();
    step();
    check("short_valid", out_valid, 1);
    check("short_words", out_words, 3);
    check("short_w2", out_data[143:96], 48'hC);
    check("short_pad", out_data[383:144], 0);
    repeat (4) step();

    // Fill the store with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH * RATIO; i++) send_word(rand_word(), 1'b0);
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    repeat (2) step();
    check("full_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("one_pop_in_ready", in_ready, 1);
    check("one_pop_level", level, 15);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("stream_level", level, 14 - i);
    end
    drain();

    // Continuous mixed traffic over 40 lines
    prod_done = 1'b0;
    fork
      begin
        for (int l = 0; l < 40; l++) begin
          int nw;
          nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RATIO)) : RATIO;
          for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 3) == 0) step();
            send_word(rand_word(), (k == nw - 1) && ((nw < RATIO) || ($urandom_range(0, 1) == 1)));
          end
        end
        prod_done = 1'b1;
      end
      begin
        int t;
        t = 0;
        while (!(prod_done && level == 0) && t < 6000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
          t++;
        end
        if (t >= 6000) begin
          checks++;
          errors++;
          $display("FAIL traffic_timeout actual=%0d required=0", level);
        end
      end
    join
    drain();

    // Reset in the middle of a line
    for (int k = 0; k < 5; k++) send_word(rand_word(), 1'b0);
    reset = 1'b1;
    step();
    check("midrst_level", level, 0);
    check("midrst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < RATIO; k++) send_word(WIN'(k + 'h11), 1'b0);
    step();
    step();
    check("clean_valid", out_valid, 1);
    check("clean_w0", out_data[47:0], 48'h11);
    check("clean_w7", out_data[383:336], 48'h18);
    check("clean_words", out_words, 8);
    repeat (4) step();

    // Completion and consumption on the same edge at level 4
    out_ready = 1'b0;
    for (int i = 0; i < 4 * RATIO + 7; i++) send_word(rand_word(), 1'b0);
    repeat (3) step();
    check("pre_same_level", level, 4);
    check("pre_same_valid", out_valid, 1);
    in_valid  = 1'b1;
    in_data   = rand_word();
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("same_edge_level", level, 4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
